// File: rtl/bip_control_if.sv
// Controller-facing bus: program memory fetch, datapath controls, data-memory strobes and status.
// The master side is the sequencer; the slave side is the surrounding memories and datapath.
interface bip_control_if #(
  parameter int PC_WIDTH   = 11,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);
  logic                  start;
  logic [DATA_WIDTH-1:0] Instr;
  logic [PC_WIDTH-1:0]   Instr_Addr;
  logic [PC_WIDTH-1:0]   Operand;
  logic [1:0]            SelA;
  logic                  SelB;
  logic                  WrAcc;
  logic                  Op;
  logic                  WrRam;
  logic                  RdRam;
  logic                  busy;
  logic                  halted;
  logic                  illegal;
  logic [CNT_WIDTH-1:0]  instr_count;

  modport master (
    input  start, Instr,
    output Instr_Addr, Operand, SelA, SelB, WrAcc, Op, WrRam, RdRam,
           busy, halted, illegal, instr_count
  );

  modport slave (
    output start, Instr,
    input  Instr_Addr, Operand, SelA, SelB, WrAcc, Op, WrRam, RdRam,
           busy, halted, illegal, instr_count
  );
endinterface

// File: rtl/bip_control.sv
// Fetch/execute sequencer for the 16-bit accumulator machine: PC, IR, opcode decode and
// a start/halt FSM. Two cycles per instruction; controls are only driven during EXEC.
module bip_control #(
  parameter int PC_WIDTH   = 11,
  parameter int DATA_WIDTH = 16,
  parameter int OPC_WIDTH  = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic         clk,
  input  logic         reset,
  bip_control_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef enum logic [OPC_WIDTH-1:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111
  } opc_t;

  localparam logic [1:0] SEL_MEM = 2'b00;
  localparam logic [1:0] SEL_IMM = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  localparam logic [PC_WIDTH-1:0]  PC_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                 state, next_state;
  logic [PC_WIDTH-1:0]    pc;
  logic [DATA_WIDTH-1:0]  ir;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   ill;

  logic [OPC_WIDTH-1:0]   opc;
  logic                   is_hlt;
  logic                   is_ill;

  logic [1:0]             sel_a;
  logic                   sel_b;
  logic                   wr_acc;
  logic                   alu_op;
  logic                   wr_ram;
  logic                   rd_ram;

  assign opc    = ir[DATA_WIDTH-1 -: OPC_WIDTH];
  assign is_hlt = (opc == OP_HLT);
  // Only the low eight encodings are defined; everything above runs as a counted NOP.
  assign is_ill = (opc > OP_SUBI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      ir    <= '0;
      cnt   <= '0;
      ill   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == FETCH)
        ir <= bus.Instr;
      if (state == EXEC) begin
        if (cnt != CNT_MAX)
          cnt <= cnt + CNT_ONE;
        if (!is_hlt)
          pc <= pc + PC_ONE;
        if (is_ill)
          ill <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = FETCH;
      FETCH:   next_state = EXEC;
      EXEC:    next_state = is_hlt ? HALT : FETCH;
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  // Decode is gated by EXEC so every strobe is quiet during FETCH, IDLE and HALT.
  always_comb begin
    sel_a  = SEL_MEM;
    sel_b  = 1'b0;
    wr_acc = 1'b0;
    alu_op = 1'b0;
    wr_ram = 1'b0;
    rd_ram = 1'b0;
    if (state == EXEC) begin
      case (opc)
        OP_STO: wr_ram = 1'b1;
        OP_LD: begin
          sel_a  = SEL_MEM;
          rd_ram = 1'b1;
          wr_acc = 1'b1;
        end
        OP_LDI: begin
          sel_a  = SEL_IMM;
          wr_acc = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          sel_a  = SEL_ALU;
          sel_b  = 1'b0;
          alu_op = (opc == OP_SUB);
          rd_ram = 1'b1;
          wr_acc = 1'b1;
        end
        OP_ADDI, OP_SUBI: begin
          sel_a  = SEL_ALU;
          sel_b  = 1'b1;
          alu_op = (opc == OP_SUBI);
          wr_acc = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Instr_Addr  = pc;
  assign bus.Operand     = ir[PC_WIDTH-1:0];
  assign bus.SelA        = sel_a;
  assign bus.SelB        = sel_b;
  assign bus.WrAcc       = wr_acc;
  assign bus.Op          = alu_op;
  assign bus.WrRam       = wr_ram;
  assign bus.RdRam       = rd_ram;
  assign bus.busy        = (state == FETCH) || (state == EXEC);
  assign bus.halted      = (state == HALT);
  assign bus.illegal     = ill;
  assign bus.instr_count = cnt;

endmodule

// File: tb/tb_bip_control.sv
// Bench for bip_control: program/data memories and an accumulator model around the controller,
// with per-EXEC expectations queued up front and popped as each instruction executes.
module tb_bip_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bip_control_if #(.PC_WIDTH(11), .DATA_WIDTH(16), .CNT_WIDTH(16)) bus ();

  bip_control #(.PC_WIDTH(11), .DATA_WIDTH(16), .OPC_WIDTH(5), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic [10:0] pc;
    logic [6:0]  ctrl;   // {WrAcc, WrRam, RdRam, SelA[1:0], SelB, Op}
    logic [15:0] acc;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  logic [15:0] pmem [0:2047];
  logic [15:0] ram  [0:2047];
  logic [15:0] acc;
  logic [15:0] opb;
  int          wr_pulses = 0;
  int          overlap = 0;
  logic        pre_we = 1'b0;
  logic [10:0] pre_addr = '0;
  logic [15:0] pre_data = '0;

  assign bus.Instr = pmem[bus.Instr_Addr];
  assign opb = bus.SelB ? {5'b0, bus.Operand} : ram[bus.Operand];

  // Datapath model: accumulator captures on negedge.
  always @(negedge clk) begin
    if (reset) acc <= '0;
    else if (bus.WrAcc) begin
      case (bus.SelA)
        2'b00:   acc <= ram[bus.Operand];
        2'b01:   acc <= {5'b0, bus.Operand};
        2'b10:   acc <= bus.Op ? acc - opb : acc + opb;
        default: acc <= acc;
      endcase
    end
  end

  // Data memory samples the write strobe on the posedge that ends EXEC.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.WrRam) begin
      ram[bus.Operand] <= acc;
      wr_pulses <= wr_pulses + 1;
    end
    if (bus.WrRam && bus.WrAcc) overlap <= overlap + 1;
  end

  function automatic logic [15:0] enc(input logic [4:0] o, input logic [10:0] a);
    return {o, a};
  endfunction

  task automatic clear_pmem(input logic [15:0] fill);
    for (int i = 0; i < 2048; i++) pmem[i] = fill;
  endtask

  task automatic poke_ram(input logic [10:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_cpu;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic push_exp(input logic [10:0] pc, input logic [6:0] ctrl, input logic [15:0] a);
    exp_t e;
    e.pc = pc; e.ctrl = ctrl; e.acc = a;
    sbq.push_back(e);
  endtask

  // Steps n instructions starting in FETCH; ends one posedge past the last EXEC.
  task automatic run_prog(input int n, input string tag);
    exp_t e;
    logic [6:0] got;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL %s scoreboard empty at instr %0d", tag, i);
        return;
      end
      e = sbq.pop_front();
      got = {bus.WrAcc, bus.WrRam, bus.RdRam, bus.SelA, bus.SelB, bus.Op};
      if (bus.Instr_Addr !== e.pc) begin
        bad++;
        $display("FAIL %s pc[%0d] got=%0h exp=%0h", tag, i, bus.Instr_Addr, e.pc);
      end
      total++;
      if (got !== e.ctrl) begin
        bad++;
        $display("FAIL %s ctrl[%0d] got=%b exp=%b", tag, i, got, e.ctrl);
      end
      @(negedge clk); #1;
      total++;
      if (acc !== e.acc) begin
        bad++;
        $display("FAIL %s acc[%0d] got=%h exp=%h", tag, i, acc, e.acc);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    clear_pmem(16'h0000);
    pmem[0] = enc(5'b00101, 11'd5);
    do_reset;
    total++;
    if ({bus.busy, bus.halted, bus.illegal, bus.Instr_Addr, bus.instr_count} !== 30'd0) begin
      bad++;
      $display("FAIL reset_state got busy=%b halted=%b pc=%h cnt=%h", bus.busy, bus.halted,
               bus.Instr_Addr, bus.instr_count);
    end
    start_cpu;
    @(posedge clk); #1;
    total++;
    if (bus.WrAcc !== 1'b1 || bus.SelA !== 2'b10 || bus.SelB !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_exec got WrAcc=%b SelA=%b SelB=%b exp 1 10 1", bus.WrAcc, bus.SelA, bus.SelB);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({bus.WrAcc, bus.WrRam, bus.RdRam, bus.SelA, bus.SelB, bus.Op, bus.busy, bus.halted} !== 9'd0 ||
        bus.instr_count !== 16'd0 || bus.Instr_Addr !== 11'd0) begin
      bad++;
      $display("FAIL reset_mid_exec got WrAcc=%b SelA=%b busy=%b cnt=%h pc=%h exp all 0",
               bus.WrAcc, bus.SelA, bus.busy, bus.instr_count, bus.Instr_Addr);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.Instr_Addr !== 11'd0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle[%0d] got pc=%h busy=%b exp 0 0", i, bus.Instr_Addr, bus.busy);
      end
    end
  endtask

  task automatic test_program;
    clear_pmem(16'h0000);
    pmem[0] = enc(5'b00011, 11'd7);
    pmem[1] = enc(5'b00101, 11'd3);
    pmem[2] = enc(5'b00111, 11'd2);
    pmem[3] = enc(5'b00001, 11'h010);
    pmem[4] = enc(5'b00000, 11'd0);
    do_reset;
    wr_pulses = 0;
    overlap = 0;
    push_exp(11'd0, 7'b1000100, 16'd7);
    push_exp(11'd1, 7'b1001010, 16'd10);
    push_exp(11'd2, 7'b1001011, 16'd8);
    push_exp(11'd3, 7'b0100000, 16'd8);
    push_exp(11'd4, 7'b0000000, 16'd8);
    start_cpu;
    run_prog(5, "prog");
    total++;
    if (bus.halted !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL prog_halted got halted=%b busy=%b exp 1 0", bus.halted, bus.busy);
    end
    total++;
    if (bus.instr_count !== 16'd5 || bus.Instr_Addr !== 11'd4) begin
      bad++;
      $display("FAIL prog_final got cnt=%0d pc=%0d exp 5 4", bus.instr_count, bus.Instr_Addr);
    end
    total++;
    if (ram[11'h010] !== 16'd8 || wr_pulses != 1) begin
      bad++;
      $display("FAIL prog_store got ram=%h pulses=%0d exp 0008 1", ram[11'h010], wr_pulses);
    end
    total++;
    if (overlap != 0) begin
      bad++;
      $display("FAIL prog_wr_overlap got=%0d exp=0", overlap);
    end
  endtask

  task automatic test_halt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = ~bus.start;
      @(posedge clk); #1;
      total++;
      if (bus.halted !== 1'b1 || bus.Instr_Addr !== 11'd4 || bus.instr_count !== 16'd5 ||
          {bus.WrAcc, bus.WrRam, bus.RdRam, bus.SelA, bus.SelB, bus.Op} !== 7'd0) begin
        bad++;
        $display("FAIL halt_absorb[%0d] got halted=%b pc=%0d cnt=%0d exp 1 4 5 strobes 0",
                 i, bus.halted, bus.Instr_Addr, bus.instr_count);
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_mem;
    clear_pmem(16'h0000);
    pmem[0] = enc(5'b00010, 11'h020);
    pmem[1] = enc(5'b00100, 11'h020);
    pmem[2] = enc(5'b00000, 11'd0);
    do_reset;
    poke_ram(11'h020, 16'h1234);
    push_exp(11'd0, 7'b1010000, 16'h1234);
    push_exp(11'd1, 7'b1011000, 16'h2468);
    push_exp(11'd2, 7'b0000000, 16'h2468);
    start_cpu;
    run_prog(3, "mem");
    total++;
    if (bus.halted !== 1'b1 || bus.instr_count !== 16'd3) begin
      bad++;
      $display("FAIL mem_final got halted=%b cnt=%0d exp 1 3", bus.halted, bus.instr_count);
    end
  endtask

  task automatic test_illegal;
    clear_pmem(16'h0000);
    pmem[0] = enc(5'b00011, 11'd1);
    pmem[1] = enc(5'b11111, 11'h7ff);
    pmem[2] = enc(5'b00000, 11'd0);
    do_reset;
    push_exp(11'd0, 7'b1000100, 16'd1);
    push_exp(11'd1, 7'b0000000, 16'd1);
    push_exp(11'd2, 7'b0000000, 16'd1);
    start_cpu;
    run_prog(3, "ill");
    total++;
    if (bus.illegal !== 1'b1 || bus.instr_count !== 16'd3 || bus.Instr_Addr !== 11'd2) begin
      bad++;
      $display("FAIL ill_final got ill=%b cnt=%0d pc=%0d exp 1 3 2", bus.illegal, bus.instr_count,
               bus.Instr_Addr);
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (bus.illegal !== 1'b1) begin
      bad++;
      $display("FAIL ill_sticky got=%b exp=1", bus.illegal);
    end
    do_reset;
    #1;
    total++;
    if (bus.illegal !== 1'b0) begin
      bad++;
      $display("FAIL ill_reset_clear got=%b exp=0", bus.illegal);
    end
  endtask

  task automatic test_wrap;
    clear_pmem(enc(5'b01000, 11'd0));
    do_reset;
    start_cpu;
    for (int i = 0; i < 2049; i++) begin
      @(posedge clk); #1;
      if (i == 2047) begin
        total++;
        if (bus.Instr_Addr !== 11'd2047) begin
          bad++;
          $display("FAIL wrap_pre got pc=%0d exp 2047", bus.Instr_Addr);
        end
      end
      @(posedge clk); #1;
      if (i == 2047) begin
        total++;
        if (bus.Instr_Addr !== 11'd0) begin
          bad++;
          $display("FAIL wrap_post got pc=%0d exp 0", bus.Instr_Addr);
        end
      end
    end
    total++;
    if (bus.Instr_Addr !== 11'd1 || bus.instr_count !== 16'd2049 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL wrap_final got pc=%0d cnt=%0d busy=%b exp 1 2049 1", bus.Instr_Addr,
               bus.instr_count, bus.busy);
    end
    clear_pmem(16'h0000);
    do_reset;
  endtask

  initial begin
    bus.start = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      ram[i] = '0;
      pmem[i] = '0;
    end
    test_reset;
    test_program;
    test_halt;
    test_mem;
    test_illegal;
    test_wrap;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
- Fetch/execute sequencer for the 16-bit accumulator datapath (data_path).
- Holds the program counter and instruction register, and decodes the 5-bit opcode into SelA/SelB/WrAcc/Op plus the data-memory strobes.
- Runs a start/halt FSM. Sits between program memory, data memory and the datapath, and is the only driver of the datapath's control inputs.

Parameters:
- PC_WIDTH, 11, program/data address width; equals the Operand field width.
- DATA_WIDTH, 16, instruction width.
- OPC_WIDTH, 5, opcode width (Instr[15:11]).
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; controller state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; leaves IDLE when sampled high.
- Instr  in  16  program-memory read data for Instr_Addr; valid before the posedge that closes FETCH.
- Instr_Addr  out  11  program counter.
- Operand  out  11  IR[10:0], to datapath Operand.
- SelA  out  2  00 = memory data, 01 = immediate, 10 = ALU result.
- SelB  out  1  ALU operand B: 1 = immediate, 0 = memory data.
- WrAcc  out  1  accumulator write enable.
- Op  out  1  ALU operation: 0 = add, 1 = subtract.
- WrRam  out  1  data-memory write strobe (address Operand, data In_Data).
- RdRam  out  1  data-memory read strobe.
- busy  out  1  high in FETCH or EXEC.
- halted  out  1  high in HALT.
- illegal  out  1  sticky flag: an undefined opcode was executed.
- instr_count  out  16  number of retired instructions; saturates.

Behaviour:
- Reset (async, any state, mid-instruction included):
  - state = IDLE; PC, IR, instr_count and illegal clear to 0.
  - All control outputs are 0; busy = halted = 0.
- FSM states (posedge): IDLE, FETCH, EXEC, HALT.
  - IDLE -> FETCH when start = 1; otherwise stays in IDLE.
  - FETCH: IR <= Instr. Always goes to EXEC. PC is unchanged.
  - EXEC: drives the decoded controls for the full cycle.
    - If the opcode is HLT: go to HALT; PC is not incremented; instr_count is still incremented.
    - Otherwise: PC <= PC + 1 (wraps 2047 -> 0), instr_count += 1 (holds at 0xFFFF), go to FETCH.
  - HALT: absorbing; start is ignored. Only reset exits.
- Throughput: exactly 2 cycles per instruction.
- Datapath timing: the datapath ACC captures on negedge. Controls set by the posedge that enters EXEC are therefore stable half a cycle before the ACC write. Data memory samples WrRam on the posedge that ends EXEC.
- Control outputs outside EXEC: SelA = 00, all other controls 0. Operand = IR[10:0] at all times.
- EXEC decode (any signal not listed is 0):
  - 00000 HLT: no strobes.
  - 00001 STO: WrRam = 1.
  - 00010 LD: SelA = 00, RdRam = 1, WrAcc = 1.
  - 00011 LDI: SelA = 01, WrAcc = 1.
  - 00100 ADD: SelA = 10, SelB = 0, Op = 0, RdRam = 1, WrAcc = 1.
  - 00101 ADDI: SelA = 10, SelB = 1, Op = 0, WrAcc = 1.
  - 00110 SUB: as ADD with Op = 1.
  - 00111 SUBI: as ADDI with Op = 1.
  - Any other opcode: executes as NOP (no strobes, PC advances, counted); illegal <= 1 at the end of EXEC and stays set until reset.
- WrAcc and WrRam are never asserted in the same cycle.
- start held high during FETCH/EXEC has no effect.
- Immediates are zero-extended by the datapath; the controller passes Operand through unmodified.

Test Plan:
- Reset/idle: assert reset mid-EXEC of ADDI 5 -> outputs go to 0 immediately, state IDLE, instr_count = 0. Release reset with start = 0 for 10 cycles -> Instr_Addr stays 0, busy = 0.
- Program LDI 7; ADDI 3; SUBI 2; STO 0x010; HLT, with a model datapath:
  - ACC = 7, 10, 8 after each EXEC.
  - WrRam pulses once with Operand = 0x010 and data 8.
  - halted after 10 cycles; instr_count = 5; Instr_Addr = 4.
- Memory path: RAM[0x020] = 0x1234. Program LD 0x020; ADD 0x020; HLT -> RdRam = 1 in both EXECs, ACC = 0x2468, SelB = 0 during ADD.
- Illegal opcode 11111 between LDI 1 and HLT -> no WrAcc/WrRam in that EXEC, illegal = 1, PC advances, instr_count = 3. illegal stays 1 until reset.
- PC wrap: preload a NOP stream (illegal opcodes), run 2049 instructions -> Instr_Addr goes 2047 -> 0; instr_count = 2049.
- Halt absorption: after HLT, toggle start for 20 cycles -> state, PC and instr_count unchanged; all strobes stay 0.
